fifo_rd_packer: RTL

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_packer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops WIDTH-bit words from the read side of a FIFO and packs
// LANES of them into one output word with a per-lane keep mask. A flush
// request emits a partially filled word. Data lands one rclk after the pop,
// so the read strobe looks ahead to avoid bubbles without ever overflowing
// the accumulator.
module fifo_rd_packer #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                   rclk,
    input  logic                   rrstn,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic [WIDTH-1:0]       rdata,
    input  logic                   flush,
    output logic                   pk_valid,
    input  logic                   pk_ready,
    output logic [WIDTH*LANES-1:0] pk_data,
    output logic [LANES-1:0]       pk_keep
);

    localparam int DW = WIDTH * LANES;
    localparam int CW = $clog2(LANES + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(LANES);
    localparam logic [CW:0]   LANES_W  = (CW + 1)'(LANES);

    // Packing state.
    logic [DW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_pend;
    logic             r_fl_req;

    // Output register.
    logic [DW-1:0]    r_pk_data;
    logic [LANES-1:0] r_pk_keep;
    logic             r_pk_valid;

    // Combinational decisions for this cycle.
    logic             w_full;
    logic             w_move_req;
    logic             w_out_free;
    logic             w_move;
    logic             w_fl_drop;
    logic [CW-1:0]    w_cnt_base;
    logic [CW-1:0]    w_lane;
    logic [CW:0]      w_fill;
    logic             w_out_free_next;
    logic             w_room;
    logic             w_pop;
    logic [DW-1:0]    w_acc_next;
    logic [CW-1:0]    w_cnt_next;
    logic [LANES-1:0] w_keep_next;

    assign w_full     = (r_cnt == FULL_CNT);
    assign w_move_req = w_full || (r_fl_req && !r_pend && (r_cnt != '0));
    assign w_out_free = !r_pk_valid || pk_ready;
    assign w_move     = w_move_req && w_out_free;

    // A flush that finds nothing buffered and nothing in flight is dropped.
    assign w_fl_drop  = r_fl_req && !r_pend && (r_cnt == '0);

    // When the current word leaves this edge, the landing byte restarts at lane 0.
    assign w_cnt_base = w_move ? '0 : r_cnt;
    assign w_lane     = w_cnt_base;

    // Lanes committed after this edge: bytes held plus the byte landing now.
    assign w_fill     = {1'b0, w_cnt_base} + (CW + 1)'(r_pend);

    // The output register is guaranteed free next cycle when it is free now
    // and this edge does not load it; a word that fills up then moves at once.
    assign w_out_free_next = !w_move && w_out_free;

    // A byte popped now lands next edge. It fits if a lane is still free, or
    // if the word completes exactly and is certain to move on that same edge.
    assign w_room = (w_fill < LANES_W) || ((w_fill == LANES_W) && w_out_free_next);

    assign w_pop  = rrstn && !rempty && !r_fl_req && w_room;
    assign rinc   = w_pop;

    // Next accumulator: cleared on move so unused lanes of a later partial word read 0.
    always_comb begin
        // NOTE: every signal driven here gets a full default first; a path
        // that leaves one unassigned would infer a latch.
        w_acc_next = w_move ? '0 : r_acc;
        for (int i = 0; i < LANES; i++) begin
            if (r_pend && (w_lane == CW'(i))) begin
                w_acc_next[i*WIDTH +: WIDTH] = rdata;
            end
        end
    end

    assign w_cnt_next = w_cnt_base + CW'(r_pend);

    // Keep mask for a moving word: one bit per filled lane, contiguous from lane 0.
    always_comb begin
        w_keep_next = '0;
        for (int i = 0; i < LANES; i++) begin
            w_keep_next[i] = (r_cnt > CW'(i));
        end
    end

    // Accumulator, lane counter, in-flight flag and flush request.
    always_ff @(posedge rclk or negedge rrstn) begin
        // NOTE: state registers use non-blocking assignment so every block
        // sees the pre-edge value regardless of evaluation order.
        if (!rrstn) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_pend   <= 1'b0;
            r_fl_req <= 1'b0;
        end else begin
            r_acc    <= w_acc_next;
            r_cnt    <= w_cnt_next;
            r_pend   <= w_pop;
            // A flush arriving on a move edge is satisfied by that move.
            r_fl_req <= (r_fl_req || flush) && !w_move && !w_fl_drop;
        end
    end

    // Output register: load on move, drop valid on transfer, hold while stalled.
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            r_pk_data  <= '0;
            r_pk_keep  <= '0;
            r_pk_valid <= 1'b0;
        end else if (w_move) begin
            r_pk_data  <= r_acc;
            r_pk_keep  <= w_keep_next;
            r_pk_valid <= 1'b1;
        end else if (pk_ready) begin
            r_pk_valid <= 1'b0;
        end
    end

    assign pk_valid = r_pk_valid;
    assign pk_data  = r_pk_data;
    assign pk_keep  = r_pk_keep;

endmodule
